// File: rtl/interrupt_request_unit.sv
// Interrupt request register front end: per-pin synchroniser, edge/level sensing with re-arm,
// registered IRR, pending flag and lowest-index encoder. Optional input deglitch filter: IRQ_DEGLITCH_EN.
module interrupt_request_unit #(
  parameter int NUM_IRQ         = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEGLITCH_CYCLES = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       write_initial_command_word_1,
  input  logic [NUM_IRQ-1:0]         trigger_mode,
  input  logic                       freeze,
  input  logic [NUM_IRQ-1:0]         clear_interrupt_request,
  input  logic [NUM_IRQ-1:0]         interrupt_request_pin,
  output logic [NUM_IRQ-1:0]         interrupt_request_register,
  output logic                       interrupt_pending,
  output logic [$clog2(NUM_IRQ)-1:0] highest_request_index
);

  localparam int IDX_W = $clog2(NUM_IRQ);

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] sync_pin;
  logic [NUM_IRQ-1:0] filt_pin;
  logic [NUM_IRQ-1:0] low_latch;
  logic [NUM_IRQ-1:0] low_next;
  logic [NUM_IRQ-1:0] irr_next;
  logic [NUM_IRQ-1:0] edge_evt;
  logic [IDX_W-1:0]   lowest_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= interrupt_request_pin;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_pin = sync_q[SYNC_STAGES-1];

`ifdef IRQ_DEGLITCH_EN
  localparam int CNT_W = $clog2(DEGLITCH_CYCLES + 1);

  logic [CNT_W-1:0]   dg_cnt [NUM_IRQ];
  logic [NUM_IRQ-1:0] filt_q;

  // Counter tracks consecutive cycles of disagreement; the output flips on the last one.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      filt_q <= '0;
      for (int i = 0; i < NUM_IRQ; i++) dg_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (sync_pin[i] == filt_q[i]) begin
          dg_cnt[i] <= '0;
        end else if (dg_cnt[i] == CNT_W'(DEGLITCH_CYCLES - 1)) begin
          filt_q[i] <= sync_pin[i];
          dg_cnt[i] <= '0;
        end else begin
          dg_cnt[i] <= dg_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign filt_pin = filt_q;
`else
  assign filt_pin = sync_pin;
`endif

  assign edge_evt = low_latch & filt_pin & ~trigger_mode;

  // A captured edge drops the low latch so a fresh low level is needed before the next capture.
  always_comb begin
    irr_next = interrupt_request_register;
    low_next = low_latch;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (write_initial_command_word_1 || clear_interrupt_request[i]) begin
        irr_next[i] = 1'b0;
        low_next[i] = 1'b0;
      end else if (freeze) begin
        if (!filt_pin[i]) low_next[i] = 1'b1;
      end else if (trigger_mode[i]) begin
        irr_next[i] = filt_pin[i];
        if (!filt_pin[i]) low_next[i] = 1'b1;
      end else if (edge_evt[i]) begin
        irr_next[i] = 1'b1;
        low_next[i] = 1'b0;
      end else if (!filt_pin[i]) begin
        low_next[i] = 1'b1;
      end
    end
  end

  always_comb begin
    lowest_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (interrupt_request_register[i]) lowest_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      low_latch                  <= '0;
      interrupt_request_register <= '0;
      interrupt_pending          <= 1'b0;
      highest_request_index      <= '0;
    end else begin
      low_latch                  <= low_next;
      interrupt_request_register <= irr_next;
      interrupt_pending          <= |interrupt_request_register;
      highest_request_index      <= lowest_idx;
    end
  end

endmodule

// File: tb/tb_interrupt_request_unit.sv
// Scoreboard bench for interrupt_request_unit: directed scenarios then random traffic,
// compared against a cycle-level reference model of the IRR rules.
module tb_interrupt_request_unit;
  localparam int N    = 8;
  localparam int SYNC = 2;
  localparam int DEG  = 3;
  localparam int IW   = $clog2(N);
`ifdef IRQ_DEGLITCH_EN
  localparam int EXTRA = DEG;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT = SYNC + 1 + EXTRA;

  logic          clock = 1'b0;
  logic          reset, icw1, freeze;
  logic [N-1:0]  tm, clr, pin;
  logic [N-1:0]  irr;
  logic          pend;
  logic [IW-1:0] idx;

  interrupt_request_unit #(.NUM_IRQ(N), .SYNC_STAGES(SYNC), .DEGLITCH_CYCLES(DEG)) dut (
    .clock(clock), .reset(reset), .write_initial_command_word_1(icw1),
    .trigger_mode(tm), .freeze(freeze), .clear_interrupt_request(clr),
    .interrupt_request_pin(pin), .interrupt_request_register(irr),
    .interrupt_pending(pend), .highest_request_index(idx));

  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0]  irr;
    logic          pend;
    logic [IW-1:0] idx;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
  endfunction

  // Reference model: pins seen through a SYNC-deep history, "armed" = a low level has been observed
  logic [N-1:0] m_irr, m_armed;
  logic [N-1:0] hist[$];
`ifdef IRQ_DEGLITCH_EN
  logic [N-1:0] m_filt;
  int           m_cnt[N];
`endif

  function automatic logic [IW-1:0] lowest(logic [N-1:0] v);
    logic [N-1:0] iso;
    if (v == '0) return '0;
    iso = v & (~v + N'(1));
    return IW'($clog2(iso));
  endfunction

  function automatic void model_reset();
    m_irr = '0;
    m_armed = '0;
    hist.delete();
    for (int k = 0; k <= SYNC; k++) hist.push_back('0);
`ifdef IRQ_DEGLITCH_EN
    m_filt = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif
  endfunction

  function automatic void model_step();
    exp_t e;
    logic [N-1:0] sp, fp, nirr, narm;
    if (reset) begin
      model_reset();
      e.irr = '0; e.pend = 1'b0; e.idx = '0;
      q.push_back(e);
      return;
    end
    hist.push_front(pin);
    sp = hist[SYNC];
    void'(hist.pop_back());
`ifdef IRQ_DEGLITCH_EN
    fp = m_filt;
    for (int i = 0; i < N; i++) begin
      if (sp[i] != m_filt[i]) begin
        m_cnt[i]++;
        if (m_cnt[i] == DEG) begin m_filt[i] = sp[i]; m_cnt[i] = 0; end
      end else m_cnt[i] = 0;
    end
`else
    fp = sp;
`endif
    nirr = m_irr;
    narm = m_armed;
    for (int i = 0; i < N; i++) begin
      if (icw1 || clr[i]) begin
        nirr[i] = 1'b0;
        narm[i] = 1'b0;
      end else begin
        if (freeze) ;
        else if (tm[i]) nirr[i] = fp[i];
        else if (m_armed[i] && fp[i]) begin nirr[i] = 1'b1; narm[i] = 1'b0; end
        if (!fp[i]) narm[i] = 1'b1;
      end
    end
    e.pend = |m_irr;
    e.idx  = lowest(m_irr);
    e.irr  = nirr;
    m_irr   = nirr;
    m_armed = narm;
    q.push_back(e);
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic cycles(int n);
    repeat (n) cycle();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("sb_irr", 32'(irr), 32'(e.irr));
        check("sb_pending", 32'(pend), 32'(e.pend));
        check("sb_index", 32'(idx), 32'(e.idx));
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    reset = 1'b1; icw1 = 1'b0; freeze = 1'b0; tm = '0; clr = '0; pin = '0;
    model_reset();
    cycles(2);
    check("reset_irr", 32'(irr), 0);
    check("reset_pending", 32'(pend), 0);
    reset = 1'b0;

    // Edge capture on IR3
    cycles(3 + EXTRA);
    pin = 8'h08;
    cycles(LAT - 1);
    check("edge_not_yet", 32'(irr), 0);
    cycle();
    check("edge_capture", 32'(irr), 32'h08);
    check("edge_pend_lag", 32'(pend), 0);
    cycle();
    check("edge_pend", 32'(pend), 1);
    check("edge_index", 32'(idx), 3);

    // Clear with pin still high must not re-capture
    clr = 8'h08; cycle(); clr = '0;
    check("rearm_clear", 32'(irr), 0);
    cycles(4);
    check("rearm_stays0", 32'(irr), 0);
    pin = 8'h00; cycles(1 + EXTRA);
    pin = 8'h08; cycles(LAT + 1);
    check("rearm_recapture", 32'(irr), 32'h08);
    pin = 8'h00; cycles(LAT + 1);
    check("edge_hold_pin_low", 32'(irr), 32'h08);

    // Level mode
    clr = '1; cycle(); clr = '0;
    tm = 8'hFF; pin = 8'h81;
    cycles(LAT + 2);
    check("level_irr", 32'(irr), 32'h81);
    check("level_index0", 32'(idx), 0);
    pin = 8'h80;
    cycles(LAT + 2);
    check("level_drop", 32'(irr), 32'h80);
    check("level_index7", 32'(idx), 7);
    clr = 8'h80; cycle(); clr = '0;
    check("level_clear", 32'(irr), 0);
    cycle();
    check("level_reassert", 32'(irr), 32'h80);

    // Freeze and clear priority
    tm = 8'h00; pin = 8'h00;
    cycles(LAT + 1);
    pin = 8'h04;
    cycles(LAT + 1);
    check("freeze_setup", 32'(irr), 32'h84);
    freeze = 1'b1; pin = 8'h24;
    cycles(LAT + 1);
    check("freeze_hold", 32'(irr), 32'h84);
    clr = 8'h04; cycle(); clr = '0;
    check("freeze_clear", 32'(irr), 32'h80);
    freeze = 1'b0; cycle();
    check("freeze_release", 32'(irr), 32'hA0);

    // Init word and async reset
    tm = 8'hFF; pin = 8'hFF;
    cycles(LAT + 1);
    check("icw1_setup", 32'(irr), 32'hFF);
    icw1 = 1'b1; cycle(); icw1 = 1'b0;
    check("icw1_clear", 32'(irr), 0);
    pin = 8'hF0;
    cycles(LAT + 2);
    check("pre_reset_index", 32'(idx), 4);
    #1;
    reset = 1'b1;
    #2;
    check("async_irr", 32'(irr), 0);
    check("async_pending", 32'(pend), 0);
    check("async_index", 32'(idx), 0);
    model_reset();
    cycles(2);
    reset = 1'b0;
    tm = 8'h00; pin = 8'h00;
    cycles(LAT + 1);
    clr = '1; cycle(); clr = '0;
    cycles(2);

`ifdef IRQ_DEGLITCH_EN
    pin = 8'h02; cycles(DEG - 1);
    pin = 8'h00; cycles(LAT + 2);
    check("glitch_rejected", 32'(irr), 0);
    pin = 8'h02; cycles(DEG + 1);
    pin = 8'h00; cycles(LAT + 2);
    check("pulse_accepted", 32'(irr), 32'h02);
    clr = '1; cycle(); clr = '0;
`endif

    // Random traffic checked by the scoreboard
    for (int c = 0; c < 1500; c++) begin
      reset  = ($urandom_range(0, 299) == 0);
      icw1   = ($urandom_range(0, 39) == 0);
      freeze = ($urandom_range(0, 7) == 0);
      clr    = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 49) == 0) tm = N'($urandom);
      pin = pin ^ (N'($urandom) & N'($urandom) & N'($urandom));
      cycle();
    end
    reset = 1'b0; icw1 = 1'b0; freeze = 1'b0; clr = '0;
    cycles(2);
    @(posedge clock);
    #2;
    check("queue_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/interrupt_request_unit.md
Name: interrupt_request_unit

Overview:
- Parametrised successor to the 8259 IRR front end: NUM_IRQ request pins, each synchronised, edge- or level-sensed per channel, and latched into a registered IRR.
- Adds per-channel trigger mode, input synchronisers, edge re-arm tracking, a registered pending flag and a registered lowest-index-pending encoder.
- Sits between the IR pins and the priority resolver / in-service logic of the PIC.

Parameters:
- NUM_IRQ, 8, number of request channels (2..32).
- SYNC_STAGES, 2, synchroniser flops per pin (>=1).
- DEGLITCH_CYCLES, 3, stable cycles required by the optional filter (>=1, ignored when the filter is compiled out).

Ports:
- clock  in  1  system clock; all state is updated on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- write_initial_command_word_1  in  1  synchronous re-initialisation pulse (ICW1 write).
- trigger_mode  in  NUM_IRQ  per channel: 1 = level, 0 = edge.
- freeze  in  1  holds IRR set behaviour during the INTA sequence.
- clear_interrupt_request  in  NUM_IRQ  one-hot or multi-hot clear strobe from control logic.
- interrupt_request_pin  in  NUM_IRQ  asynchronous IR pins.
- interrupt_request_register  out  NUM_IRQ  registered IRR.
- interrupt_pending  out  1  registered OR of the IRR.
- highest_request_index  out  $clog2(NUM_IRQ)  registered lowest set IRR index; 0 when the IRR is empty.

Behaviour:
- Reset: synchronisers, low latches, IRR, interrupt_pending, highest_request_index and filter state all go to 0, asynchronously and immediately.
- Synchroniser: SYNC_STAGES flops per pin, shifting every cycle. Its output is sync_pin.
- Filtered input filt_pin:
  - filt_pin = sync_pin when the filter is compiled out.
  - Otherwise, see Optional Feature.
- Low latch, per channel i, priority order:
  - write_initial_command_word_1 -> 0.
  - clear_interrupt_request[i] -> 0.
  - Edge captured into IRR this cycle -> 0 (re-arm: a new low level is required).
  - filt_pin[i] == 0 -> 1.
  - Otherwise hold.
- Edge event: edge[i] = low_latch[i] & filt_pin[i] & ~trigger_mode[i].
- IRR bit i, priority order each cycle:
  1. write_initial_command_word_1 -> 0.
  2. clear_interrupt_request[i] -> 0. Clear beats any set in the same cycle.
  3. freeze -> hold.
  4. Level mode -> filt_pin[i]. The bit follows the pin and drops when the pin falls.
  5. Edge mode -> set on edge[i], otherwise hold. The bit stays set until cleared, even if the pin falls.
- Edge during freeze: not captured, and the low latch is not cleared. The edge is captured on the first unfrozen cycle if the pin is still high.
- Level mode after clear: with the pin still high, the IRR bit re-asserts on the next unfrozen cycle.
- trigger_mode change: takes effect the next cycle with no IRR flush. Switching edge->level makes the bit follow the pin; switching level->edge holds the current value.
- Latency with the filter off:
  - Pin change -> IRR: SYNC_STAGES+1 clock edges.
  - IRR -> interrupt_pending and highest_request_index: +1 edge.
- highest_request_index: lowest-numbered set bit (IR0 is highest priority), computed from the current IRR and registered.
- Multi-hot clear: all selected bits clear in the same cycle.
- Reset mid-operation: all state clears immediately. After release, edge channels need a low-then-high sequence before they can assert.

Optional Feature:
- Macro: IRQ_DEGLITCH_EN.
- When defined:
  - Each channel has a counter of width $clog2(DEGLITCH_CYCLES+1), reset to 0.
  - filt_pin[i] changes only after sync_pin[i] has differed from filt_pin[i] for DEGLITCH_CYCLES consecutive cycles.
  - The counter resets to 0 on any cycle where they agree.
  - write_initial_command_word_1 does not affect the filter.
  - This adds DEGLITCH_CYCLES cycles of latency.
- When not defined: no counters are built, and filt_pin = sync_pin.

Test Plan:
- Edge capture:
  - Stimulus: reset, trigger_mode=0, pin[3] 0->1.
  - Required response: IRR=8'h08 after 3 edges (filter off); highest_request_index=3 and pending=1 one edge later; pin[3] dropping keeps IRR=8'h08.
- Edge re-arm:
  - Stimulus: after the capture above, clear_interrupt_request=8'h08 for one cycle while pin[3] stays high.
  - Required response: IRR=0 and stays 0. Required response after pin[3] low 1 cycle then high: IRR=8'h08 again.
- Level mode:
  - Stimulus: trigger_mode=8'hFF, pin=8'h81.
  - Required response: IRR=8'h81 and index=0.
  - Stimulus: pin[0] drops.
  - Required response: IRR=8'h80 and index=7.
  - Stimulus: clear 8'h80 with pin[7] high.
  - Required response: IRR 8'h00 for one cycle, then 8'h80.
- Freeze and clear priority:
  - Stimulus: freeze=1 with a pin[5] edge arriving.
  - Required response: IRR unchanged.
  - Stimulus: clear bit 2 during freeze.
  - Required response: bit 2 clears.
  - Stimulus: freeze released.
  - Required response: bit 5 sets one edge later.
- Init and async reset:
  - Stimulus: write_initial_command_word_1 pulse with IRR=8'hFF.
  - Required response: IRR=0 next edge.
  - Stimulus: reset asserted mid-cycle.
  - Required response: all outputs 0 before the next clock edge.
- IRQ_DEGLITCH_EN defined, DEGLITCH_CYCLES=3:
  - Stimulus: a 2-cycle high glitch on pin[1].
  - Required response: no IRR change.
  - Stimulus: a 4-cycle high pulse.
  - Required response: IRR=8'h02.
